// File: rtl/pat101_pkg.sv
// Shared types and helpers for the "101" frame controller.
package pat101_pkg;

  // Scan state of the bit-serial "101" detector.
  typedef enum logic [1:0] {
    ScS0  = 2'b00,
    ScS1  = 2'b01,
    ScS10 = 2'b10
  } scan_st_e;

  // Frame-level control state.
  typedef enum logic [1:0] {
    CtlIdle  = 2'b00,
    CtlAccum = 2'b01,
    CtlDone  = 2'b10
  } ctl_st_e;

  // Width of a per-word match count; a word can hold at most W/3+1 matches when carrying in S10.
  function automatic int unsigned wcnt_w(input int unsigned w);
    return $clog2(w / 3 + 2);
  endfunction

endpackage

// File: rtl/pat101_word_scan.sv
// Combinational unrolled "101" scan of one word, MSB first.
module pat101_word_scan
  import pat101_pkg::*;
#(
  parameter int unsigned W = 10,
  localparam int unsigned WcW = wcnt_w(W)
) (
  input  scan_st_e         start_i,
  input  logic [W-1:0]     word_i,
  output scan_st_e         end_o,
  output logic [WcW-1:0]   count_o
);

  scan_st_e         st;
  logic [WcW-1:0]   cnt;

  // Walk the detector across every bit; a match returns to S0 so matches never overlap.
  always_comb begin
    st  = start_i;
    cnt = '0;
    for (int i = W - 1; i >= 0; i--) begin
      unique case (st)
        ScS0:  st = word_i[i] ? ScS1 : ScS0;
        ScS1:  st = word_i[i] ? ScS1 : ScS10;
        ScS10: begin
          if (word_i[i]) cnt = cnt + WcW'(1);
          st = ScS0;
        end
        default: st = ScS0;
      endcase
    end
    end_o   = st;
    count_o = cnt;
  end

endmodule

// File: rtl/pat101_frame_ctrl.sv
// Frame controller: scans words, accumulates a saturating match count, presents it per frame.
module pat101_frame_ctrl
  import pat101_pkg::*;
#(
  parameter int unsigned W     = 10,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned CARRY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned WcW = wcnt_w(W);
  localparam logic [CNT_W:0] SatMax = {1'b0, {CNT_W{1'b1}}};

  ctl_st_e            ctl_q, ctl_d;
  scan_st_e           scan_q, scan_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;
  logic               in_ready_q, in_ready_d;

  scan_st_e           scan_start;
  scan_st_e           word_end;
  logic [WcW-1:0]     word_cnt;
  logic [CNT_W:0]     sum;
  logic [CNT_W-1:0]   acc_new;
  logic               ovf_new;
  logic               accept;

  assign accept     = in_valid && in_ready_q;
  assign scan_start = ((CARRY == 0) || (ctl_q == CtlIdle)) ? ScS0 : scan_q;

  pat101_word_scan #(
    .W (W)
  ) u_word_scan (
    .start_i (scan_start),
    .word_i  (in_data),
    .end_o   (word_end),
    .count_o (word_cnt)
  );

  // Saturating add of this word's matches; ovf stays sticky within the frame.
  always_comb begin
    sum     = {1'b0, acc_q} + (CNT_W + 1)'(word_cnt);
    acc_new = (sum > SatMax) ? SatMax[CNT_W-1:0] : sum[CNT_W-1:0];
    ovf_new = ovf_q || (sum > SatMax);
  end

  // Control FSM next state and register updates.
  always_comb begin
    ctl_d       = ctl_q;
    scan_d      = scan_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    in_ready_d  = in_ready_q;
    unique case (ctl_q)
      CtlIdle, CtlAccum: begin
        if (accept) begin
          if (in_last) begin
            ctl_d       = CtlDone;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
            out_count_d = acc_new;
            out_ovf_d   = ovf_new;
            acc_d       = '0;
            ovf_d       = 1'b0;
            scan_d      = ScS0;
          end else begin
            ctl_d  = CtlAccum;
            acc_d  = acc_new;
            ovf_d  = ovf_new;
            scan_d = word_end;
          end
        end
      end
      CtlDone: begin
        if (out_valid_q && out_ready) begin
          ctl_d       = CtlIdle;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: ctl_d = CtlIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q       <= CtlIdle;
      scan_q      <= ScS0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      ctl_q       <= ctl_d;
      scan_q      <= scan_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (ctl_q != CtlIdle);

endmodule

// File: doc/pat101_frame_ctrl.md
# pat101_frame_ctrl

Frame-level controller that sequences the non-overlapping "101" pattern detector over a stream of W-bit words. Each frame is a run of words delimited by `in_last`. The block scans every word MSB-first, one word per cycle, and can carry detector state across word boundaries. It accumulates a saturating per-frame match count and presents it through a valid/ready result port. It sits between the word source and the downstream statistics consumer.

## Interface
- `W`, 10: word width in bits.
- `CNT_W`, 8: width of the frame count.
- `CARRY`, 1: 1 = a pattern may span adjacent words within a frame; 0 = scan state is cleared at every word start.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  controller can accept a word.
- `in_data`  in  W  word; bit W-1 is scanned first.
- `in_last`  in  1  word is the final word of its frame.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_count`  out  CNT_W  non-overlapping "101" matches in the frame, saturated.
- `out_ovf`  out  1  frame count saturated.
- `busy`  out  1  a frame is in progress (at least one word accepted, result not yet accepted).

## Operation
- Scan FSM, one step per bit:
  - S0: on 1 go to S1; on 0 stay in S0.
  - S1: on 1 stay in S1; on 0 go to S10.
  - S10: on 1 count a match and go to S0; on 0 go to S0.
- Matching is greedy, leftmost-first and non-overlapping. `1010101010` scanned from S0 yields 2 matches and ends in S10.
- Per-word scan is unrolled combinationally: inputs are start state and word; outputs are end state and a match count of width `$clog2(W/3+2)`.
- Start state for each word:
  - S0 at frame start.
  - S0 at every word when `CARRY`=0.
  - Otherwise the registered end state of the previous word.
- Control FSM:
  - IDLE: no frame in progress.
    - Accepted word with `in_last`=0 → ACCUM.
    - Accepted word with `in_last`=1 → DONE.
  - ACCUM: frame in progress.
    - Accepted word with `in_last`=1 → DONE.
  - DONE: result held.
    - `out_valid`&&`out_ready` → IDLE.
- Word accept condition: `in_valid`&&`in_ready`.
- Accumulator update: acc + word count, saturating at 2^CNT_W-1.
  - `ovf` is set if the true sum exceeds 2^CNT_W-1.
  - `ovf` is sticky until the frame result is accepted.
- On entry to DONE, `out_count` and `out_ovf` take the final values, including the last word. Accumulator, `ovf` and scan state are then cleared for the next frame.
- Words presented while `in_ready`=0 are not consumed and have no effect.

## Timing
- Reset values of all outputs:
  - `in_ready`=1.
  - `out_valid`=0.
  - `out_count`=0.
  - `out_ovf`=0.
  - `busy`=0.
- Reset also forces control FSM to IDLE, scan state to S0 and accumulator to 0.
- Reset asserted mid-frame discards the partial frame with no result emitted.
- `in_ready` is registered and equals `!out_valid`; it has no combinational path from `out_ready`.
- Throughput: one word per cycle within a frame.
- Latency: `out_valid` rises the cycle after the `in_last` word is accepted.
- After the result handshake, `in_ready` returns to 1 the following cycle, giving a one-cycle minimum gap between frames.
- While `out_valid`=1, `out_count` and `out_ovf` are stable until the handshake, regardless of how long `out_ready` stays low.
- A single-word frame (`in_last` on the first word) is legal.
- A frame of N words leaves DONE no earlier than N+1 cycles after its first accept.
- No input combination is illegal. `in_last` is ignored when `in_valid`=0.

## Structure
- Shared package `pat101_pkg` holds:
  - scan state enum (S0, S1, S10; 2-bit encoding);
  - control state enum (IDLE, ACCUM, DONE);
  - function `wcnt_w(W)` returning `$clog2(W/3+2)`.
- Sub-module `pat101_word_scan` (combinational; parameter `W`; ports start state, word, end state, count) holds the unrolled per-bit FSM.
- The top holds the control FSM, scan-state register, saturating accumulator and output registers.

## Test plan
- Single-word frame `10'b1010101010`, `CARRY`=1 → `out_count`=2, `out_ovf`=0, `out_valid` one cycle after accept.
- Two-word frame `10'b0000000010` then `10'b1000000000`:
  - `CARRY`=1 → count 1.
  - `CARRY`=0 → count 0.
- Six-word frame of `10'b1011011010` (3 matches per word, ends in S0), `CARRY`=1, `CNT_W`=4 → `out_count`=15, `out_ovf`=1.
- Backpressure on single-word frame `10'b0000000101`: hold `out_ready`=0 for 5 cycles with `in_valid`=1 held → `in_ready`=0 throughout, `out_count`=1 stable, no word consumed. Then raise `out_ready` → `in_ready`=1 next cycle.
- Reset mid-frame: drop `rst_n` after two words of a frame → all outputs at reset values. Then single-word frame `10'b0000000101` → count 1.
- Back-to-back frames with `in_valid` held high: counts of each frame are independent and no word is lost across the one-cycle gap.
